// File: rtl/ncc_sched.sv
// ncc_sched: loads one descriptor into ncc, walks the SEARCH_W x SEARCH_W window grid, reports the best hit.
// Beats land on the engine one cycle after acceptance; the source stalls on desc_ready, the window buffer via win_ack.
module ncc_sched #(
  parameter int DESC_BEATS = 64,
  parameter int SEARCH_W   = 17,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        desc_valid,
  input  logic [31:0] desc_data,
  output logic        desc_ready,
  output logic        ncc_clr,
  output logic        ncc_desc_data_ready,
  output logic [31:0] ncc_desc_in,
  input  logic        ncc_done_desc,
  output logic        win_req,
  output logic [4:0]  win_x,
  output logic [4:0]  win_y,
  input  logic        win_ack,
  output logic        ncc_window_data_ready,
  input  logic        ncc_done_window,
  input  logic [31:0] ncc_best_ncc,
  input  logic [8:0]  ncc_best_idx,
  output logic [31:0] result_ncc,
  output logic [8:0]  result_idx,
  output logic [4:0]  result_x,
  output logic [4:0]  result_y
);

  localparam int BW = (DESC_BEATS > 1) ? $clog2(DESC_BEATS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(DESC_BEATS - 1);
  localparam logic [8:0]    LAST_WIN  = 9'(SEARCH_W * SEARCH_W - 1);
  localparam logic [4:0]    LAST_X    = 5'(SEARCH_W - 1);
  localparam logic [8:0]    STEP      = 9'(SEARCH_W);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_DESC, WAIT_DESC, FETCH_WIN, FIRE, WAIT_NCC, CONVERT, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] beat_cnt;
  logic [8:0]    win_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [8:0]    rem;
  logic [4:0]    quo;
  logic          tmo_hit;

  // The counter starts at 1 on entry so it counts the cycle that launched the wait.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = LOAD_DESC;
      LOAD_DESC: if (desc_valid && beat_cnt == LAST_BEAT) state_nxt = WAIT_DESC;
      WAIT_DESC: begin
        if (ncc_done_desc) state_nxt = FETCH_WIN;
        else if (tmo_hit)  state_nxt = DONE;
      end
      FETCH_WIN: if (win_ack) state_nxt = FIRE;
      FIRE:      state_nxt = WAIT_NCC;
      WAIT_NCC: begin
        if (ncc_done_window) state_nxt = (win_cnt == LAST_WIN) ? CONVERT : FETCH_WIN;
        else if (tmo_hit)    state_nxt = DONE;
      end
      CONVERT:   if (rem < STEP) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy                  = (state != IDLE);
    desc_ready            = (state == LOAD_DESC);
    win_req               = (state == FETCH_WIN);
    ncc_window_data_ready = (state == FIRE);
    done                  = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error               <= 1'b0;
      ncc_clr             <= 1'b0;
      ncc_desc_data_ready <= 1'b0;
      ncc_desc_in         <= '0;
      win_x               <= '0;
      win_y               <= '0;
      result_ncc          <= '0;
      result_idx          <= '0;
      result_x            <= '0;
      result_y            <= '0;
      beat_cnt            <= '0;
      win_cnt             <= '0;
      tmo_cnt             <= '0;
      rem                 <= '0;
      quo                 <= '0;
    end else begin
      ncc_clr             <= 1'b0;
      ncc_desc_data_ready <= 1'b0;

      if (state_nxt != state)
        tmo_cnt <= TW'(1);
      else if (state == WAIT_DESC || state == WAIT_NCC)
        tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            ncc_clr    <= 1'b1;
            error      <= 1'b0;
            beat_cnt   <= '0;
            win_cnt    <= '0;
            win_x      <= '0;
            win_y      <= '0;
            result_ncc <= '0;
            result_idx <= '0;
            result_x   <= '0;
            result_y   <= '0;
          end
        end
        LOAD_DESC: begin
          if (desc_valid) begin
            ncc_desc_in         <= desc_data;
            ncc_desc_data_ready <= 1'b1;
            beat_cnt            <= beat_cnt + 1'b1;
          end
        end
        WAIT_DESC: begin
          if (!ncc_done_desc && tmo_hit) error <= 1'b1;
        end
        WAIT_NCC: begin
          if (ncc_done_window) begin
            if (win_cnt == LAST_WIN) begin
              result_ncc <= ncc_best_ncc;
              result_idx <= ncc_best_idx;
              rem        <= ncc_best_idx;
              quo        <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              if (win_x == LAST_X) begin
                win_x <= '0;
                win_y <= win_y + 1'b1;
              end else begin
                win_x <= win_x + 1'b1;
              end
            end
          end else if (tmo_hit) begin
            error <= 1'b1;
          end
        end
        CONVERT: begin
          // One subtraction per cycle; the remainder is the column once it drops below a row.
          if (rem >= STEP) begin
            rem <= rem - STEP;
            quo <= quo + 1'b1;
          end else begin
            result_x <= rem[4:0];
            result_y <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
